load_tid_tracker: RTL
=====================

Name: load_tid_tracker

Overview:
- Parametrised tracker for outstanding load transactions between the load unit and the data-cache memory interface.
- Allocates a memory transaction ID (TID) per issued load and stores that load's scoreboard transaction ID, byte offset, size and sign.
- Matches cache responses by TID and returns aligned, sign/zero-extended results to writeback.
- Handles flushes without reusing TIDs that are still in flight.

Parameters:
- XLEN, 32, data width in bits; legal values are 32 and 64.
- NR_ENTRIES, 2, number of outstanding loads; range 1..2**TID_WIDTH.
- TID_WIDTH, 2, width of the memory transaction ID.
- TRANS_ID_WIDTH, 2, width of the scoreboard transaction ID.
- OFFSET_WIDTH, $clog2(XLEN/8), width of the byte offset within an XLEN word (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  kill all in-flight loads
- alloc_valid_i  in  1  load issue request
- alloc_ready_o  out  1  free entry available and no flush this cycle
- alloc_trans_id_i  in  TRANS_ID_WIDTH  scoreboard ID of the load
- alloc_offset_i  in  OFFSET_WIDTH  byte offset of the load
- alloc_size_i  in  2  00 byte, 01 half, 10 word, 11 dword
- alloc_sign_i  in  1  1 = sign-extend
- alloc_tid_o  out  TID_WIDTH  TID granted; valid when alloc_valid_i && alloc_ready_o
- rsp_valid_i  in  1  cache response valid (always accepted)
- rsp_tid_i  in  TID_WIDTH  TID of the response
- rsp_data_i  in  XLEN  raw aligned word from the cache
- result_valid_o  out  1  result to writeback (single-cycle pulse)
- result_trans_id_o  out  TRANS_ID_WIDTH  scoreboard ID of the result
- result_data_o  out  XLEN  extracted and extended data
- protocol_err_o  out  1  single-cycle pulse on a response to a FREE entry or to a TID >= NR_ENTRIES
- count_o  out  $clog2(NR_ENTRIES+1)  number of non-FREE entries
- busy_o  out  1  count_o != 0

Behaviour:
- Entry state machine, one per entry: FREE, PENDING, KILLED.
  - FREE -> PENDING on alloc handshake.
  - PENDING -> FREE on a matching response; produces a result.
  - PENDING -> KILLED on flush_i.
  - KILLED -> FREE on a matching response; produces no result.
- A TID equals its entry index. A TID is reusable only after its entry returns to FREE.
- alloc_ready_o = (some entry FREE) && !flush_i. The lowest-index FREE entry is granted. alloc_tid_o is combinational from the FREE mask.
- No same-cycle reuse: an entry freed by a response in cycle N is allocatable from cycle N+1 at the earliest.
- Result latency: one cycle. A response in cycle N gives result_valid_o, result_trans_id_o and result_data_o registered in cycle N+1.
- Extraction:
  - Shift rsp_data_i right by 8*offset.
  - Keep 8/16/32/64 bits according to size.
  - Extend with the top kept bit when sign=1, otherwise with zeros.
  - XLEN=32 with size 11 is treated as word.
- Offsets that are misaligned for the given size are not checked; misalignment is trapped upstream.
- Simultaneous events:
  - flush_i + response to a PENDING entry in the same cycle: the entry goes to FREE and no result is produced.
  - flush_i + alloc_valid_i: no handshake, because ready is low.
  - Alloc and response to different entries in the same cycle: both take effect.
- Bad responses: a response to a FREE entry or to an out-of-range TID changes no state, produces no result, and pulses protocol_err_o in N+1.
- count_o and busy_o are registered and reflect the state after each clock edge.
- Reset, including mid-operation: all entries FREE. result_valid_o=0, result_trans_id_o=0, result_data_o=0, protocol_err_o=0, count_o=0, busy_o=0. alloc_ready_o=1 while flush_i=0. Responses arriving after reset for pre-reset TIDs flag protocol_err_o.
- Sizing: implementation is expected at 150–250 lines. Elaboration asserts NR_ENTRIES <= 2**TID_WIDTH and XLEN in {32, 64}.

Test Plan:
- Basic load, XLEN=32: alloc trans_id=1, offset=2, size=00, sign=1 -> tid=0. Then response tid=0, data=32'h12_80_34_56 -> next cycle result_valid_o=1, trans_id=1, data=32'hFFFF_FF80.
- Fill and out-of-order return, NR_ENTRIES=2: two allocs -> tids 0 then 1, alloc_ready_o=0, count_o=2. Respond tid=1 then tid=0 -> results come back in response order with the matching trans_ids. A third alloc issued in the same cycle as the tid=1 response is granted tid 1 only in the following cycle.
- Flush with loads in flight: two PENDING entries, pulse flush_i -> both KILLED, count_o stays 2, alloc_ready_o=0. Responses for both -> no result_valid_o, count_o falls to 0, alloc_ready_o returns to 1.
- Flush in the same cycle as a response: PENDING tid=0 plus flush_i plus response tid=0 -> no result, entry FREE next cycle. Alloc_valid_i held high during the flush cycle -> no grant.
- Stray response: response to FREE tid=1, and response to tid=3 with NR_ENTRIES=2 -> protocol_err_o pulses one cycle each time, state unchanged.
- XLEN=64 dword and reset: alloc size=11, sign=0, offset=0; response data=64'h8000_0000_0000_0001 -> result equals the input. Assert rst_i with one entry PENDING -> all outputs reset, and a later response to that tid raises protocol_err_o.

Source files
------------

// File: rtl/load_tid_tracker_if.sv
// Bundle of load-issue, cache-response and writeback signals between the
// load unit, the tracker and the data-cache memory interface.
interface load_tid_tracker_if #(
    parameter int XLEN           = 32,
    parameter int NR_ENTRIES     = 2,
    parameter int TID_WIDTH      = 2,
    parameter int TRANS_ID_WIDTH = 2
);
    localparam int OFFSET_WIDTH = $clog2(XLEN / 8);
    localparam int CNT_WIDTH    = $clog2(NR_ENTRIES + 1);

    logic                      flush_i;
    logic                      alloc_valid_i;
    logic                      alloc_ready_o;
    logic [TRANS_ID_WIDTH-1:0] alloc_trans_id_i;
    logic [OFFSET_WIDTH-1:0]   alloc_offset_i;
    logic [1:0]                alloc_size_i;
    logic                      alloc_sign_i;
    logic [TID_WIDTH-1:0]      alloc_tid_o;
    logic                      rsp_valid_i;
    logic [TID_WIDTH-1:0]      rsp_tid_i;
    logic [XLEN-1:0]           rsp_data_i;
    logic                      result_valid_o;
    logic [TRANS_ID_WIDTH-1:0] result_trans_id_o;
    logic [XLEN-1:0]           result_data_o;
    logic                      protocol_err_o;
    logic [CNT_WIDTH-1:0]      count_o;
    logic                      busy_o;

    // Tracker side
    modport slave (
        input  flush_i, alloc_valid_i, alloc_trans_id_i, alloc_offset_i,
               alloc_size_i, alloc_sign_i, rsp_valid_i, rsp_tid_i, rsp_data_i,
        output alloc_ready_o, alloc_tid_o, result_valid_o, result_trans_id_o,
               result_data_o, protocol_err_o, count_o, busy_o
    );

    // Load unit / cache side
    modport master (
        output flush_i, alloc_valid_i, alloc_trans_id_i, alloc_offset_i,
               alloc_size_i, alloc_sign_i, rsp_valid_i, rsp_tid_i, rsp_data_i,
        input  alloc_ready_o, alloc_tid_o, result_valid_o, result_trans_id_o,
               result_data_o, protocol_err_o, count_o, busy_o
    );
endinterface

// File: rtl/load_tid_tracker.sv
// Outstanding-load tracker: hands out memory TIDs, remembers per-load
// scoreboard ID / offset / size / sign, and turns cache responses into
// aligned, extended writeback results one cycle later. Flushed loads keep
// their TID until the cache answers, so a TID is never reused in flight.
module load_tid_tracker #(
    parameter int XLEN           = 32,
    parameter int NR_ENTRIES     = 2,
    parameter int TID_WIDTH      = 2,
    parameter int TRANS_ID_WIDTH = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    load_tid_tracker_if.slave bus
);
    localparam int OFFSET_WIDTH = $clog2(XLEN / 8);
    localparam int CNT_WIDTH    = $clog2(NR_ENTRIES + 1);

    if (NR_ENTRIES < 1 || NR_ENTRIES > (1 << TID_WIDTH)) begin : g_bad_nr_entries
        $error("load_tid_tracker: NR_ENTRIES must be in 1..2**TID_WIDTH");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("load_tid_tracker: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        KILLED  = 2'd2
    } entry_state_e;

    entry_state_e              state_q    [NR_ENTRIES];
    entry_state_e              state_d    [NR_ENTRIES];
    logic [TRANS_ID_WIDTH-1:0] trans_id_q [NR_ENTRIES];
    logic [OFFSET_WIDTH-1:0]   offset_q   [NR_ENTRIES];
    logic [1:0]                size_q     [NR_ENTRIES];
    logic                      sign_q     [NR_ENTRIES];

    logic [NR_ENTRIES-1:0]     free_mask;
    logic [NR_ENTRIES-1:0]     pending_mask;
    logic [NR_ENTRIES-1:0]     rsp_hit;
    logic                      alloc_ready;
    logic                      alloc_fire;
    logic [TID_WIDTH-1:0]      alloc_tid;
    logic                      rsp_pending;
    logic                      rsp_bad;
    logic [TRANS_ID_WIDTH-1:0] sel_trans_id;
    logic [OFFSET_WIDTH-1:0]   sel_offset;
    logic [1:0]                sel_size;
    logic                      sel_sign;

    logic                      result_vld_p0;
    logic [XLEN-1:0]           result_data_p0;
    logic [CNT_WIDTH-1:0]      count_p0;

    logic                      result_vld_p1;
    logic [TRANS_ID_WIDTH-1:0] result_trans_id_p1;
    logic [XLEN-1:0]           result_data_p1;
    logic                      perr_p1;
    logic [CNT_WIDTH-1:0]      count_p1;
    logic                      busy_p1;

    // Shift the raw word down to the addressed byte, keep the access size and
    // extend it; on XLEN=32 a dword request degrades to a word.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [XLEN-1:0]         raw,
        input logic [OFFSET_WIDTH-1:0] off,
        input logic [1:0]              size,
        input logic                    sign
    );
        logic        [XLEN-1:0] shifted;
        logic signed [XLEN-1:0] res;
        shifted = raw >> {off, 3'b000};
        case (size)
            2'b00: begin
                if (sign) res = XLEN'($signed(shifted[7:0]));
                else      res = XLEN'(shifted[7:0]);
            end
            2'b01: begin
                if (sign) res = XLEN'($signed(shifted[15:0]));
                else      res = XLEN'(shifted[15:0]);
            end
            2'b10: begin
                if (sign) res = XLEN'($signed(shifted[31:0]));
                else      res = XLEN'(shifted[31:0]);
            end
            default: begin
                if (XLEN == 64)  res = shifted;
                else if (sign)   res = XLEN'($signed(shifted[31:0]));
                else             res = XLEN'(shifted[31:0]);
            end
        endcase
        return res;
    endfunction

    // Entry masks, response decode and metadata of the responding entry
    always_comb begin
        free_mask    = '0;
        pending_mask = '0;
        rsp_hit      = '0;
        sel_trans_id = '0;
        sel_offset   = '0;
        sel_size     = '0;
        sel_sign     = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            free_mask[i]    = (state_q[i] == FREE);
            pending_mask[i] = (state_q[i] == PENDING);
            rsp_hit[i]      = bus.rsp_valid_i && (bus.rsp_tid_i == TID_WIDTH'(i));
            if (rsp_hit[i]) begin
                sel_trans_id = trans_id_q[i];
                sel_offset   = offset_q[i];
                sel_size     = size_q[i];
                sel_sign     = sign_q[i];
            end
        end
        rsp_pending = |(rsp_hit & pending_mask);
        rsp_bad     = bus.rsp_valid_i && !(|(rsp_hit & ~free_mask));
    end

    // Lowest-index FREE entry is offered; a flush blocks allocation
    always_comb begin
        alloc_tid = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (free_mask[i]) alloc_tid = TID_WIDTH'(i);
        end
        alloc_ready = (|free_mask) && !bus.flush_i;
        alloc_fire  = bus.alloc_valid_i && alloc_ready;
    end

    // Per-entry next state and the resulting occupancy count
    always_comb begin
        count_p0 = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                FREE: begin
                    if (alloc_fire && (alloc_tid == TID_WIDTH'(i))) state_d[i] = PENDING;
                end
                PENDING: begin
                    if (rsp_hit[i])        state_d[i] = FREE;
                    else if (bus.flush_i)  state_d[i] = KILLED;
                end
                KILLED: begin
                    if (rsp_hit[i]) state_d[i] = FREE;
                end
                default: state_d[i] = FREE;
            endcase
            if (state_d[i] != FREE) count_p0 = count_p0 + CNT_WIDTH'(1);
        end
    end

    // Result is produced only for a live (un-flushed) pending load
    always_comb begin
        result_vld_p0  = rsp_pending && !bus.flush_i;
        result_data_p0 = extract_load(bus.rsp_data_i, sel_offset, sel_size, sel_sign);
    end

    // Entry state register
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (rst_i) state_q[i] <= FREE;
            else       state_q[i] <= state_d[i];
        end
    end

    // Capture load attributes into the granted entry
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (alloc_fire && (alloc_tid == TID_WIDTH'(i))) begin
                trans_id_q[i] <= bus.alloc_trans_id_i;
                offset_q[i]   <= bus.alloc_offset_i;
                size_q[i]     <= bus.alloc_size_i;
                sign_q[i]     <= bus.alloc_sign_i;
            end
        end
    end

    // ---- p0 -> p1: registered writeback, error pulse and occupancy ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_vld_p1      <= 1'b0;
            result_trans_id_p1 <= '0;
            result_data_p1     <= '0;
            perr_p1            <= 1'b0;
            count_p1           <= '0;
            busy_p1            <= 1'b0;
        end else begin
            result_vld_p1      <= result_vld_p0;
            result_trans_id_p1 <= sel_trans_id;
            result_data_p1     <= result_data_p0;
            perr_p1            <= rsp_bad;
            count_p1           <= count_p0;
            busy_p1            <= (count_p0 != '0);
        end
    end

    assign bus.alloc_ready_o     = alloc_ready;
    assign bus.alloc_tid_o       = alloc_tid;
    assign bus.result_valid_o    = result_vld_p1;
    assign bus.result_trans_id_o = result_trans_id_p1;
    assign bus.result_data_o     = result_data_p1;
    assign bus.protocol_err_o    = perr_p1;
    assign bus.count_o           = count_p1;
    assign bus.busy_o            = busy_p1;
endmodule
